// File: rtl/ysyx_25030093_lsu_pkg.sv
// Shared types for the load/store unit: op encodings, FSM states and decode helpers.
package ysyx_25030093_lsu_pkg;

  typedef enum logic [3:0] {
    LSU_LB  = 4'd0,
    LSU_LH  = 4'd1,
    LSU_LW  = 4'd2,
    LSU_LBU = 4'd4,
    LSU_LHU = 4'd5,
    LSU_SB  = 4'd8,
    LSU_SH  = 4'd9,
    LSU_SW  = 4'd10
  } lsu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } lsu_state_t;

  function automatic logic is_store(input logic [3:0] op);
    return op[3];
  endfunction

  // Undefined encodings report as misaligned so they complete with an error and never touch the bus.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
    logic bad;
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: bad = 1'b0;
      LSU_LH, LSU_LHU, LSU_SH: bad = off[0];
      LSU_LW, LSU_SW:          bad = (off != 2'b00);
      default:                 bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_25030093_lsu_if.sv
// Execute-side request, memory bus and writeback signals of the LSU in one bundle.
interface ysyx_25030093_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_op;
  logic [ADDR_W-1:0]     in_addr;
  logic [DATA_W-1:0]     in_wdata;
  logic [4:0]            in_rd;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [DATA_W-1:0]     wb_data;
  logic [4:0]            wb_rd;
  logic                  wb_wen;
  logic                  wb_err;

  modport master (
    output in_valid, in_op, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  wb_valid, wb_data, wb_rd, wb_wen, wb_err,
    output wb_ready
  );

  modport slave (
    input  in_valid, in_op, in_addr, in_wdata, in_rd,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output wb_valid, wb_data, wb_rd, wb_wen, wb_err,
    input  wb_ready
  );
endinterface

// File: rtl/ysyx_25030093_lsu_align.sv
// Combinational lane logic: store strobes/replicated data and extended load result.
module ysyx_25030093_lsu_align
  import ysyx_25030093_lsu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    wstrb_o = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = 32'h0;
    case (op_i)
      LSU_SB: begin
        wstrb_o = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      LSU_SH: begin
        wstrb_o = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      LSU_SW:  wstrb_o = 4'b1111;
      LSU_LB:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      LSU_LBU: rdata_o = {24'h0, shifted[7:0]};
      LSU_LH:  rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      LSU_LHU: rdata_o = {16'h0, shifted[15:0]};
      LSU_LW:  rdata_o = shifted;
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25030093_lsu.sv
// Single-outstanding load/store unit: IDLE -> REQ -> WAIT -> RESP, one op at a time.
module ysyx_25030093_lsu
  import ysyx_25030093_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_25030093_lsu_if.slave        lsu_io
);

  lsu_state_t          state_q, state_d;
  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [4:0]          rd_q;
  logic [DATA_W-1:0]   data_q;
  logic                wen_q;
  logic                err_q;

  logic                in_ready;
  logic                mem_req;
  logic                wb_valid;
  logic                accept;
  logic                misal;
  logic [3:0]          lane_strb;
  logic [DATA_W-1:0]   lane_wdata;
  logic [DATA_W-1:0]   load_ext;

  assign accept = (state_q == S_IDLE) && lsu_io.in_valid;
  assign misal  = is_misaligned(lsu_io.in_op, lsu_io.in_addr[1:0]);

  ysyx_25030093_lsu_align u_align (
    .op_i    (op_q),
    .off_i   (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (lsu_io.mem_rdata),
    .wstrb_o (lane_strb),
    .wdata_o (lane_wdata),
    .rdata_o (load_ext)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    mem_req  = 1'b0;
    wb_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (lsu_io.in_valid) state_d = misal ? S_RESP : S_REQ;
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (lsu_io.mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lsu_io.mem_rvalid) state_d = S_RESP;
      end
      S_RESP: begin
        wb_valid = 1'b1;
        if (lsu_io.wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 4'h0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 5'h0;
      data_q  <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= lsu_io.in_op;
        addr_q  <= lsu_io.in_addr;
        wdata_q <= lsu_io.in_wdata;
        rd_q    <= lsu_io.in_rd;
        data_q  <= '0;
        wen_q   <= 1'b0;
        err_q   <= misal;
      end else if (state_q == S_WAIT && lsu_io.mem_rvalid) begin
        // Stores complete on the write ack and never write back data.
        data_q <= is_store(op_q) ? '0 : load_ext;
        wen_q  <= ~is_store(op_q);
      end
    end
  end

  assign lsu_io.in_ready  = in_ready;
  assign lsu_io.mem_req   = mem_req;
  assign lsu_io.mem_we    = mem_req & is_store(op_q);
  assign lsu_io.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign lsu_io.mem_wdata = lane_wdata;
  assign lsu_io.mem_wstrb = mem_req ? lane_strb : 4'b0000;
  assign lsu_io.wb_valid  = wb_valid;
  assign lsu_io.wb_data   = data_q;
  assign lsu_io.wb_rd     = rd_q;
  assign lsu_io.wb_wen    = wen_q;
  assign lsu_io.wb_err    = err_q;

endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
// Scoreboard bench: issue loop pushes bus/writeback expectations, responder and monitor check them.
module tb_ysyx_25030093_lsu;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rdy_dly;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [3:0]  exp_strb;
    logic [31:0] exp_mwdata;
    logic        abort;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;
    logic        abort;
  } bus_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wen;
    logic        err;
    int          rdy_dly;
    int          lat;
    int          acc_cyc;
  } wb_exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_pass;
  bit   in_wait;
  bit   stray_done;

  bus_exp_t bus_q[$];
  wb_exp_t  wb_q[$];
  vec_t     vecs[$];

  ysyx_25030093_lsu_if #(.ADDR_W(32), .DATA_W(32)) lsu_bus ();

  ysyx_25030093_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .lsu_io (lsu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: event did not occur as expected (t=%0t)", name, $time);
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] rd, input logic [31:0] rdata, input int gnt_dly,
                              input int rdy_dly, input logic [31:0] exp_data, input logic exp_err,
                              input logic [3:0] exp_strb, input logic [31:0] exp_mwdata);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata;
    v.gnt_dly = gnt_dly; v.rdy_dly = rdy_dly; v.exp_data = exp_data; v.exp_err = exp_err;
    v.exp_strb = exp_strb; v.exp_mwdata = exp_mwdata; v.abort = 1'b0;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    bus_exp_t be;
    wb_exp_t  we_;
    int       t;
    if (!v.exp_err) begin
      be.addr = {v.addr[31:2], 2'b00};
      be.we = v.op[3]; be.strb = v.exp_strb; be.wdata = v.exp_mwdata;
      be.rdata = v.rdata; be.gnt_dly = v.gnt_dly; be.abort = v.abort;
      bus_q.push_back(be);
    end
    t = 0;
    while (!lsu_bus.in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!lsu_bus.in_ready) begin
      fail("issue_timeout");
      return;
    end
    lsu_bus.in_valid = 1'b1;
    lsu_bus.in_op    = v.op;
    lsu_bus.in_addr  = v.addr;
    lsu_bus.in_wdata = v.wdata;
    lsu_bus.in_rd    = v.rd;
    @(posedge clk); #1;
    lsu_bus.in_valid = 1'b0;
    if (!v.abort) begin
      we_.data = v.exp_data; we_.rd = v.rd; we_.err = v.exp_err;
      we_.wen = !v.exp_err && !v.op[3];
      we_.rdy_dly = v.rdy_dly;
      we_.lat = v.exp_err ? 1 : 3 + v.gnt_dly;
      we_.acc_cyc = cyc;
      wb_q.push_back(we_);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(lsu_bus.in_ready), 32'd1);
    chk({tag, "_mem_req"},   32'(lsu_bus.mem_req), 32'd0);
    chk({tag, "_mem_we"},    32'(lsu_bus.mem_we), 32'd0);
    chk({tag, "_mem_wstrb"}, 32'(lsu_bus.mem_wstrb), 32'd0);
    chk({tag, "_mem_addr"},  lsu_bus.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, lsu_bus.mem_wdata, 32'd0);
    chk({tag, "_wb_valid"},  32'(lsu_bus.wb_valid), 32'd0);
    chk({tag, "_wb_data"},   lsu_bus.wb_data, 32'd0);
    chk({tag, "_wb_rd"},     32'(lsu_bus.wb_rd), 32'd0);
    chk({tag, "_wb_wen"},    32'(lsu_bus.wb_wen), 32'd0);
    chk({tag, "_wb_err"},    32'(lsu_bus.wb_err), 32'd0);
  endtask

  // Memory responder: checks each request, grants after gnt_dly, acks one cycle later.
  initial begin
    bus_exp_t be;
    int t;
    lsu_bus.mem_gnt = 1'b0;
    lsu_bus.mem_rvalid = 1'b0;
    lsu_bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && lsu_bus.mem_req) begin
        if (bus_q.size() == 0) begin
          fail("bus_unexpected_req");
          be.addr = lsu_bus.mem_addr; be.we = 1'b0; be.strb = 4'h0; be.wdata = 32'h0;
          be.rdata = 32'h0; be.gnt_dly = 0; be.abort = 1'b0;
        end else begin
          be = bus_q.pop_front();
          chk("mem_addr", lsu_bus.mem_addr, be.addr);
          chk("mem_we", 32'(lsu_bus.mem_we), 32'(be.we));
          chk("mem_wstrb", 32'(lsu_bus.mem_wstrb), 32'(be.strb));
          if (be.we) chk("mem_wdata", lsu_bus.mem_wdata, be.wdata);
        end
        for (int i = 0; i < be.gnt_dly; i++) begin
          @(negedge clk);
          chk("req_hold", 32'(lsu_bus.mem_req), 32'd1);
          chk("addr_hold", lsu_bus.mem_addr, be.addr);
          chk("strb_hold", 32'(lsu_bus.mem_wstrb), 32'(be.strb));
          chk("in_ready_busy", 32'(lsu_bus.in_ready), 32'd0);
        end
        lsu_bus.mem_gnt = 1'b1;
        @(negedge clk);
        lsu_bus.mem_gnt = 1'b0;
        chk("req_drop", 32'(lsu_bus.mem_req), 32'd0);
        chk("in_ready_wait", 32'(lsu_bus.in_ready), 32'd0);
        if (be.abort) begin
          in_wait = 1'b1;
          t = 0;
          while (rst_n && t < 50) begin @(negedge clk); t++; end
          while (!rst_n && t < 100) begin @(negedge clk); t++; end
          lsu_bus.mem_rvalid = 1'b1;
          lsu_bus.mem_rdata = 32'hFFFF_FFFF;
          @(negedge clk);
          lsu_bus.mem_rvalid = 1'b0;
          lsu_bus.mem_rdata = 32'h0;
          stray_done = 1'b1;
        end else begin
          lsu_bus.mem_rvalid = 1'b1;
          lsu_bus.mem_rdata = be.rdata;
          @(negedge clk);
          lsu_bus.mem_rvalid = 1'b0;
          lsu_bus.mem_rdata = 32'h0;
        end
      end
    end
  end

  // Writeback monitor: pops the scoreboard when the DUT presents a result.
  initial begin
    wb_exp_t e;
    bit seen;
    bit post_hs;
    int hold;
    seen = 0; post_hs = 0; hold = 0;
    lsu_bus.wb_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (post_hs) begin
        chk("in_ready_after_hs", 32'(lsu_bus.in_ready), 32'd1);
        chk("wb_valid_after_hs", 32'(lsu_bus.wb_valid), 32'd0);
        post_hs = 0;
      end
      if (!rst_n) begin
        lsu_bus.wb_ready = 1'b0;
        seen = 0;
      end else if (lsu_bus.wb_valid) begin
        if (wb_q.size() == 0) begin
          fail("wb_unexpected");
          lsu_bus.wb_ready = 1'b1;
        end else begin
          e = wb_q[0];
          if (!seen) begin
            seen = 1;
            hold = e.rdy_dly;
            chk("wb_latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
          end
          chk("wb_data", lsu_bus.wb_data, e.data);
          chk("wb_rd", 32'(lsu_bus.wb_rd), 32'(e.rd));
          chk("wb_wen", 32'(lsu_bus.wb_wen), 32'(e.wen));
          chk("wb_err", 32'(lsu_bus.wb_err), 32'(e.err));
          chk("in_ready_resp", 32'(lsu_bus.in_ready), 32'd0);
          chk("mem_req_resp", 32'(lsu_bus.mem_req), 32'd0);
          if (hold == 0) begin
            lsu_bus.wb_ready = 1'b1;
            void'(wb_q.pop_front());
            seen = 0;
            post_hs = 1;
          end else begin
            hold--;
            lsu_bus.wb_ready = 1'b0;
          end
        end
      end else begin
        lsu_bus.wb_ready = 1'b0;
      end
    end
  end

  initial begin
    vec_t v;
    int t;
    n_chk = 0; n_pass = 0; in_wait = 0; stray_done = 0;
    rst_n = 1'b0;
    lsu_bus.in_valid = 1'b0;
    lsu_bus.in_op = 4'h0;
    lsu_bus.in_addr = 32'h0;
    lsu_bus.in_wdata = 32'h0;
    lsu_bus.in_rd = 5'h0;
    #12;
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    //             op     addr          wdata         rd     rdata         g  r  exp_data      err  strb     mem_wdata
    vecs.push_back(mk(4'd2,  32'h8000_0004, 32'h0,        5'd5,  32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd0,  32'h8000_0003, 32'h0,        5'd7,  32'h80FF_FFFF, 0, 0, 32'hFFFF_FF80, 0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd4,  32'h8000_0003, 32'h0,        5'd8,  32'h80FF_FFFF, 0, 0, 32'h0000_0080, 0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd5,  32'h8000_0002, 32'h0,        5'd9,  32'h9ABC_0000, 0, 0, 32'h0000_9ABC, 0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd8,  32'h8000_0002, 32'h1234_56A5, 5'd10, 32'hFFFF_FFFF, 0, 0, 32'h0,         0, 4'b0100, 32'hA5A5_A5A5));
    vecs.push_back(mk(4'd1,  32'h8000_0001, 32'h0,        5'd11, 32'h0,         0, 0, 32'h0,         1, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd2,  32'h8000_0008, 32'h0,        5'd12, 32'h1122_3344, 3, 2, 32'h1122_3344, 0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd1,  32'h8000_0002, 32'h0,        5'd13, 32'h8001_0000, 0, 0, 32'hFFFF_8001, 0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd9,  32'h8000_0002, 32'h0000_BEEF, 5'd14, 32'hFFFF_FFFF, 0, 0, 32'h0,         0, 4'b1100, 32'hBEEF_BEEF));
    vecs.push_back(mk(4'd10, 32'h8000_000C, 32'hCAFE_F00D, 5'd15, 32'hFFFF_FFFF, 1, 0, 32'h0,         0, 4'b1111, 32'hCAFE_F00D));
    vecs.push_back(mk(4'd2,  32'h8000_0006, 32'h0,        5'd16, 32'h0,         0, 0, 32'h0,         1, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd3,  32'h8000_0000, 32'h0,        5'd17, 32'h0,         0, 0, 32'h0,         1, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd11, 32'h8000_0000, 32'h0,        5'd18, 32'h0,         0, 0, 32'h0,         1, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd0,  32'h8000_0000, 32'h0,        5'd19, 32'h0000_007F, 0, 0, 32'h0000_007F, 0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd5,  32'h8000_0000, 32'h0,        5'd20, 32'h1234_FFFF, 0, 1, 32'h0000_FFFF, 0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd8,  32'h8000_0001, 32'h0000_00FF, 5'd21, 32'hFFFF_FFFF, 1, 1, 32'h0,         0, 4'b0010, 32'hFFFF_FFFF));
    vecs.push_back(mk(4'd0,  32'h8000_0001, 32'h0,        5'd22, 32'h0000_9A00, 0, 0, 32'hFFFF_FF9A, 0, 4'b0000, 32'h0));
    vecs.push_back(mk(4'd9,  32'h8000_0001, 32'h0000_1234, 5'd23, 32'h0,         0, 0, 32'h0,         1, 4'b0000, 32'h0));

    foreach (vecs[i]) run_vec(vecs[i]);

    t = 0;
    while ((wb_q.size() != 0 || bus_q.size() != 0) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (wb_q.size() != 0 || bus_q.size() != 0) fail("drain_timeout");
    repeat (2) @(posedge clk);
    #1;

    // Abandon a load in WAIT with reset, then a stray ack must not produce a result.
    v = mk(4'd2, 32'h8000_0010, 32'h0, 5'd3, 32'h0, 0, 0, 32'h0, 0, 4'b0000, 32'h0);
    v.abort = 1'b1;
    run_vec(v);
    t = 0;
    while (!in_wait && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    if (!in_wait) fail("wait_state_timeout");
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midrst");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    t = 0;
    while (!stray_done && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    if (!stray_done) fail("stray_rvalid_timeout");
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_wb_valid", 32'(lsu_bus.wb_valid), 32'd0);
      chk("post_rst_in_ready", 32'(lsu_bus.in_ready), 32'd1);
      chk("post_rst_mem_req", 32'(lsu_bus.mem_req), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_lsu.md
Name: ysyx_25030093_lsu

Overview:
Multi-cycle load/store unit directly downstream of the execute ALU. It replaces in-ALU DPI memory calls with a registered request/response bus.
- Accepts one memory op per transaction from execute: effective address, store data, op code, rd index.
- Drives byte-lane strobes and handles alignment.
- Sign- or zero-extends load data.
- Hands the result to writeback over a valid/ready handshake.
- Only one transaction is in flight at a time; there is no buffering beyond the single response register.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed at 32; strobe width is DATA_W/8)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute presents an op
in_ready  out  1  LSU can accept an op (high only in IDLE)
in_op  in  4  lsu_op_t: {is_store, funct3}
in_addr  in  32  effective address (rs1+imm, computed upstream)
in_wdata  in  32  rs2 value for stores
in_rd  in  5  destination register
mem_req  out  1  bus request, held until granted
mem_we  out  1  1 = write
mem_addr  out  32  word-aligned address ({in_addr[31:2],2'b00})
mem_wdata  out  32  store data replicated/shifted into lane position
mem_wstrb  out  4  byte enables (0 for reads)
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  response (read data or write ack)
mem_rdata  in  32  read data, full word
wb_valid  out  1  result available
wb_ready  in  1  writeback consumes result
wb_data  out  32  extended load data; 0 for stores
wb_rd  out  5  destination register
wb_wen  out  1  1 for successful loads, 0 for stores or errors
wb_err  out  1  misaligned access

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE.
  - mem_req, mem_we, mem_wstrb, wb_valid, wb_wen, wb_err = 0.
  - mem_addr, mem_wdata, wb_data = 0; wb_rd = 0.
  - Reset mid-transaction abandons it; a late mem_rvalid arriving in IDLE is ignored.
- State machine: IDLE -> REQ -> WAIT -> RESP -> IDLE.
  - IDLE: in_ready=1.
    - On in_valid, capture op, addr, wdata, rd.
    - If misaligned (H with addr[0]=1; W with addr[1:0]!=0): go to RESP with wb_err=1, wb_wen=0, wb_data=0. No bus activity.
    - Otherwise go to REQ.
  - REQ: mem_req=1; address, we, wdata, wstrb are stable until mem_gnt. On mem_gnt, drop mem_req next cycle and go to WAIT.
  - WAIT: on mem_rvalid, register the extended data and go to RESP. mem_rvalid is not sampled in any other state.
  - RESP: wb_valid=1, outputs stable until wb_ready; on wb_ready go to IDLE.
    - No bypass: the next op is accepted only in the following cycle.
- Minimum latency: accept at cycle 0; mem_req visible in cycle 1; gnt in cycle 1; rvalid in cycle 2; wb_valid in cycle 3.
- Strobes by off = addr[1:0]:
  - SB: 4'b0001 << off; wdata = {4{wdata[7:0]}}.
  - SH: 4'b0011 << off; wdata = {2{wdata[15:0]}}.
  - SW: 4'b1111; wdata unchanged.
- Load extract: byte = rdata >> (8*off).
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- Undefined op encodings (funct3=3,6,7 loads; store funct3>2) are treated as misaligned: wb_err=1.
- Stores: wb_wen=0, wb_data=0, completed on mem_rvalid (write ack).
- Simultaneous mem_gnt in the last REQ cycle with mem_rvalid in the same cycle: rvalid is ignored. The bus guarantees rvalid at least one cycle after gnt.

Decomposition:
- Package ysyx_25030093_lsu_pkg:
  - lsu_op_t encodings: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=8, SH=9, SW=10.
  - state enum (IDLE, REQ, WAIT, RESP).
  - Helper functions: is_store(), is_misaligned().
- One sub-module: ysyx_25030093_lsu_align. Purely combinational; produces wstrb, lane-shifted wdata and the extended load result from op, off, wdata and rdata.

Test Plan:
- LW at 0x80000004, gnt in cycle 1, rdata=0xDEADBEEF in cycle 2 -> wb_valid in cycle 3, wb_data=0xDEADBEEF, wb_wen=1, wb_rd preserved.
- LB at 0x80000003, rdata=0x80FFFFFF -> wb_data=0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at 0x80000002 with rdata 0x9ABC0000 -> 0x00009ABC.
- SB at 0x80000002, wdata=0x123456A5 -> mem_we=1, mem_addr=0x80000000, mem_wstrb=4'b0100, mem_wdata=0xA5A5A5A5; after ack, wb_valid=1, wb_wen=0.
- LH at 0x80000001 -> mem_req never asserts; wb_valid in cycle 1 with wb_err=1, wb_wen=0, wb_data=0.
- Stall paths: gnt delayed 3 cycles, then wb_ready held low 2 cycles -> mem_req, mem_addr and wb_* stay stable throughout; in_ready stays 0 until the cycle after the wb handshake.
- rst_n pulsed low during WAIT, then a stray mem_rvalid -> state=IDLE, all outputs at reset values, no wb_valid generated.
